// File: rtl/mem_pkg.sv
// Shared definitions for the MIPS32 load/store unit: op encodings, FSM states and
// access-size helpers.
package mem_pkg;

   typedef enum logic [2:0] {
      OP_LB  = 3'd0,
      OP_LBU = 3'd1,
      OP_LH  = 3'd2,
      OP_LHU = 3'd3,
      OP_LW  = 3'd4,
      OP_SB  = 3'd5,
      OP_SH  = 3'd6,
      OP_SW  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StResp = 2'd2,
      StErr  = 2'd3
   } state_e;

   function automatic logic is_store(input op_e op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic logic is_half(input op_e op);
      return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
   endfunction

   function automatic logic is_word(input op_e op);
      return (op == OP_LW) || (op == OP_SW);
   endfunction

   function automatic logic is_misaligned(input op_e op, input logic [1:0] lane);
      return (is_half(op) && lane[0]) || (is_word(op) && (lane != 2'b00));
   endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load lane select: picks the byte/half addressed by lane from a
// little-endian memory word and sign- or zero-extends it to 32 bits.
module load_extend
   import mem_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [2:0]  i_op,
   input  logic [1:0]  i_lane,
   output logic [31:0] o_value
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   op_e         w_op;

   assign w_op = op_e'(i_op);

   always_comb begin
      w_byte = i_word[7:0];
      unique case (i_lane)
         2'd0: w_byte = i_word[7:0];
         2'd1: w_byte = i_word[15:8];
         2'd2: w_byte = i_word[23:16];
         2'd3: w_byte = i_word[31:24];
         default: w_byte = i_word[7:0];
      endcase
   end

   assign w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

   always_comb begin
      o_value = i_word;
      case (w_op)
         OP_LB:   o_value = {{24{w_byte[7]}}, w_byte};
         OP_LBU:  o_value = {24'h0, w_byte};
         OP_LH:   o_value = {{16{w_half[15]}}, w_half};
         OP_LHU:  o_value = {16'h0, w_half};
         default: o_value = i_word;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the EX/MEM stage and a synchronous data memory: issues one
// registered request per op, stalls the core until ack, flags misalignment and timeouts.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int unsigned DM_AW   = 10,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [2:0]       i_op,
   input  logic [31:0]      i_addr,
   input  logic [31:0]      i_wdata,
   output logic             o_busy,
   output logic             o_done,
   output logic [31:0]      o_rdata,
   output logic             o_align_err,
   output logic             o_bus_err,
   output logic             o_dm_req,
   output logic             o_dm_we,
   output logic [3:0]       o_dm_be,
   output logic [DM_AW-1:0] o_dm_addr,
   output logic [31:0]      o_dm_wdata,
   input  logic             i_dm_ack,
   input  logic [31:0]      i_dm_rdata
);

   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

   state_e            r_state;
   state_e            w_state_d;
   op_e               r_op;
   logic [1:0]        r_lane;
   logic              r_dm_we;
   logic [3:0]        r_dm_be;
   logic [DM_AW-1:0]  r_dm_addr;
   logic [31:0]       r_dm_wdata;
   logic [31:0]       r_rdata;
   logic              r_bus_err;
   logic [CntW-1:0]   r_cnt;

   op_e               w_op;
   logic              w_misaligned;
   logic              w_accept;
   logic              w_timeout;
   logic [3:0]        w_be;
   logic [31:0]       w_wdata;
   logic [31:0]       w_ext;
   logic              w_unused;

   assign w_op         = op_e'(i_op);
   assign w_misaligned = is_misaligned(w_op, i_addr[1:0]);
   assign w_accept     = (r_state == StIdle) && i_start;
   assign w_unused     = ^i_addr[31:DM_AW+2];

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = 32'h0;
      case (w_op)
         OP_SB: begin
            w_be    = 4'b0001 << i_addr[1:0];
            w_wdata = {4{i_wdata[7:0]}};
         end
         OP_SH: begin
            w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{i_wdata[15:0]}};
         end
         OP_SW: begin
            w_be    = 4'b1111;
            w_wdata = i_wdata;
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = 32'h0;
         end
      endcase
   end

   always_comb begin
      w_state_d = r_state;
      w_timeout = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (i_start) w_state_d = w_misaligned ? StErr : StReq;
         end
         StReq: begin
            // An ack landing on the final allowed cycle still completes normally.
            if (i_dm_ack) begin
               w_state_d = StResp;
            end else if (r_cnt == CntLast) begin
               w_state_d = StResp;
               w_timeout = 1'b1;
            end
         end
         StResp:  w_state_d = StIdle;
         StErr:   w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   load_extend u_load_extend (
      .i_word  (i_dm_rdata),
      .i_op    (r_op),
      .i_lane  (r_lane),
      .o_value (w_ext)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= StIdle;
         r_op       <= OP_LB;
         r_lane     <= 2'b00;
         r_dm_we    <= 1'b0;
         r_dm_be    <= 4'b0000;
         r_dm_addr  <= '0;
         r_dm_wdata <= 32'h0;
         r_rdata    <= 32'h0;
         r_bus_err  <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_state <= w_state_d;
         if (w_accept && !w_misaligned) begin
            r_op       <= w_op;
            r_lane     <= i_addr[1:0];
            r_dm_we    <= is_store(w_op);
            r_dm_be    <= w_be;
            r_dm_addr  <= i_addr[DM_AW+1:2];
            r_dm_wdata <= w_wdata;
            r_bus_err  <= 1'b0;
            r_cnt      <= '0;
         end
         if (r_state == StReq) begin
            r_bus_err <= w_timeout;
            if (i_dm_ack) begin
               if (!is_store(r_op)) r_rdata <= w_ext;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   // The done cycle leaves busy low so the core advances on the completion pulse.
   assign o_busy      = (r_state == StReq) || w_accept;
   assign o_done      = (r_state == StResp) || (r_state == StErr);
   assign o_align_err = (r_state == StErr);
   assign o_bus_err   = (r_state == StResp) && r_bus_err;
   assign o_dm_req    = (r_state == StReq);
   assign o_dm_we     = r_dm_we;
   assign o_dm_be     = r_dm_be;
   assign o_dm_addr   = r_dm_addr;
   assign o_dm_wdata  = r_dm_wdata;
   assign o_rdata     = r_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a small byte-enabled memory
// model whose ack latency can be programmed or disabled.
module tb_mem_access_unit;

   localparam int unsigned DM_AW = 10;

   logic             clk;
   logic             reset;
   logic             start;
   logic [2:0]       op;
   logic [31:0]      addr;
   logic [31:0]      wdata;
   logic             busy;
   logic             done;
   logic [31:0]      rdata;
   logic             align_err;
   logic             bus_err;
   logic             dm_req;
   logic             dm_we;
   logic [3:0]       dm_be;
   logic [DM_AW-1:0] dm_addr;
   logic [31:0]      dm_wdata;
   logic             dm_ack;
   logic [31:0]      dm_rdata;

   int tests_run = 0;
   int fails = 0;

   // memory model: ack after ack_delay cycles of dm_req; ack_force injects a stray ack
   logic [31:0] mem [0:1023];
   int          ack_delay = 0;
   bit          ack_en = 1'b1;
   bit          ack_force = 1'b0;
   int          r_wait;

   // results of the last run_op
   int          t_done_cyc;
   int          t_busy;
   bit          t_req;
   logic        t_we;
   logic [3:0]  t_be;
   logic [31:0] t_wd;
   logic [9:0]  t_addr;
   logic [31:0] t_rdata;
   logic        t_align;
   logic        t_bus;

   mem_access_unit #(
      .DM_AW   (DM_AW),
      .TIMEOUT (15)
   ) dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_start     (start),
      .i_op        (op),
      .i_addr      (addr),
      .i_wdata     (wdata),
      .o_busy      (busy),
      .o_done      (done),
      .o_rdata     (rdata),
      .o_align_err (align_err),
      .o_bus_err   (bus_err),
      .o_dm_req    (dm_req),
      .o_dm_we     (dm_we),
      .o_dm_be     (dm_be),
      .o_dm_addr   (dm_addr),
      .o_dm_wdata  (dm_wdata),
      .i_dm_ack    (dm_ack),
      .i_dm_rdata  (dm_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      dm_ack   = ack_force | (dm_req & ack_en & (r_wait == ack_delay));
      dm_rdata = ack_force ? 32'hFFFF_FFFF : mem[dm_addr];
   end

   always @(posedge clk) begin
      if (reset) begin
         mem[10'h40] <= 32'hCCDD_1ABB;
         mem[10'h41] <= 32'h0;
         mem[10'h42] <= 32'h0;
      end else if (dm_req && dm_ack && dm_we) begin
         for (int b = 0; b < 4; b++)
            if (dm_be[b]) mem[dm_addr][8*b +: 8] <= dm_wdata[8*b +: 8];
      end
      if (!dm_req || dm_ack) r_wait <= 0;
      else r_wait <= r_wait + 1;
   end

   // Called at a negedge with the DUT idle; start is held for cycle 0 only.
   // Returns at the negedge after the done cycle.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd);
      op = o; addr = a; wdata = wd; start = 1'b1;
      t_done_cyc = -1; t_busy = 0; t_req = 1'b0;
      t_we = 1'b0; t_be = 4'h0; t_wd = 32'h0; t_addr = 10'h0;
      t_rdata = 32'h0; t_align = 1'b0; t_bus = 1'b0;
      #1;
      if (busy) t_busy++;
      for (int c = 1; c <= 40 && t_done_cyc < 0; c++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         if (busy) t_busy++;
         if (dm_req && !t_req) begin
            t_req = 1'b1; t_we = dm_we; t_be = dm_be; t_wd = dm_wdata; t_addr = dm_addr;
         end
         if (done) begin
            t_done_cyc = c; t_rdata = rdata; t_align = align_err; t_bus = bus_err;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; op = 3'd0; addr = 32'h0; wdata = 32'h0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      tests_run++;
      if ({busy, done, align_err, bus_err, dm_req, dm_we, dm_be, dm_addr, dm_wdata, rdata} !== '0) begin
         fails++;
         $display("FAIL reset_outputs busy=%b done=%b req=%b we=%b be=%b addr=%h wd=%h rdata=%h exp all 0",
                  busy, done, dm_req, dm_we, dm_be, dm_addr, dm_wdata, rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_loads;
      logic [2:0]  ops  [8] = '{3'd2, 3'd2, 3'd3, 3'd0, 3'd1, 3'd0, 3'd1, 3'd4};
      logic [31:0] adrs [8] = '{32'h100, 32'h102, 32'h102, 32'h103, 32'h101, 32'h100,
                                32'h102, 32'h100};
      logic [31:0] exps [8] = '{32'h0000_1ABB, 32'hFFFF_CCDD, 32'h0000_CCDD, 32'hFFFF_FFCC,
                                32'h0000_001A, 32'hFFFF_FFBB, 32'h0000_00DD, 32'hCCDD_1ABB};
      ack_en = 1'b1; ack_delay = 0;
      for (int i = 0; i < 8; i++) begin
         run_op(ops[i], adrs[i], 32'h0);
         tests_run++;
         if (t_rdata !== exps[i] || t_done_cyc != 2 || t_align || t_bus) begin
            fails++;
            $display("FAIL load[%0d] op=%0d addr=%h rdata=%h done@%0d exp rdata=%h done@2",
                     i, ops[i], adrs[i], t_rdata, t_done_cyc, exps[i]);
         end
      end
      tests_run++;
      if (t_we !== 1'b0 || t_be !== 4'b1111 || t_addr !== 10'h40 || t_busy != 2) begin
         fails++;
         $display("FAIL load_strobes we=%b be=%b addr=%h busy=%0d exp we=0 be=1111 addr=040 busy=2",
                  t_we, t_be, t_addr, t_busy);
      end
   endtask

   task automatic test_stores;
      run_op(3'd6, 32'h106, 32'h1234_5678);
      tests_run++;
      if (t_we !== 1'b1 || t_be !== 4'b1100 || t_wd !== 32'h5678_5678 || t_addr !== 10'h41
          || t_done_cyc != 2 || t_rdata !== 32'hCCDD_1ABB) begin
         fails++;
         $display("FAIL sh_106 we=%b be=%b wd=%h addr=%h done@%0d rdata=%h exp 1 1100 56785678 041 2 ccdd1abb",
                  t_we, t_be, t_wd, t_addr, t_done_cyc, t_rdata);
      end
      run_op(3'd4, 32'h104, 32'h0);
      tests_run++;
      if (t_rdata !== 32'h5678_0000) begin
         fails++; $display("FAIL lw_after_sh rdata=%h exp 56780000", t_rdata);
      end
      run_op(3'd5, 32'h105, 32'h0000_00AB);
      tests_run++;
      if (t_we !== 1'b1 || t_be !== 4'b0010 || t_wd !== 32'hABAB_ABAB) begin
         fails++;
         $display("FAIL sb_105 we=%b be=%b wd=%h exp 1 0010 abababab", t_we, t_be, t_wd);
      end
      run_op(3'd4, 32'h104, 32'h0);
      tests_run++;
      if (t_rdata !== 32'h5678_AB00) begin
         fails++; $display("FAIL lw_after_sb rdata=%h exp 5678ab00", t_rdata);
      end
      run_op(3'd7, 32'h108, 32'hDEAD_BEEF);
      tests_run++;
      if (t_be !== 4'b1111 || t_wd !== 32'hDEAD_BEEF || t_addr !== 10'h42) begin
         fails++;
         $display("FAIL sw_108 be=%b wd=%h addr=%h exp 1111 deadbeef 042", t_be, t_wd, t_addr);
      end
      run_op(3'd4, 32'h108, 32'h0);
      tests_run++;
      if (t_rdata !== 32'hDEAD_BEEF) begin
         fails++; $display("FAIL lw_after_sw rdata=%h exp deadbeef", t_rdata);
      end
   endtask

   task automatic test_misaligned;
      logic [2:0]  ops  [3] = '{3'd2, 3'd4, 3'd6};
      logic [31:0] adrs [3] = '{32'h101, 32'h102, 32'h103};
      for (int i = 0; i < 3; i++) begin
         run_op(ops[i], adrs[i], 32'h0);
         tests_run++;
         if (t_done_cyc != 1 || t_align !== 1'b1 || t_req || t_bus !== 1'b0
             || t_rdata !== 32'hDEAD_BEEF || t_busy != 1) begin
            fails++;
            $display("FAIL misaligned[%0d] done@%0d align=%b req_seen=%b rdata=%h busy=%0d exp 1 1 0 deadbeef 1",
                     i, t_done_cyc, t_align, t_req, t_rdata, t_busy);
         end
      end
   endtask

   task automatic test_wait_states;
      // ack on the third REQ cycle (cycle 3)
      ack_delay = 2;
      run_op(3'd4, 32'h100, 32'h0);
      tests_run++;
      if (t_busy != 4 || t_done_cyc != 4 || t_rdata !== 32'hCCDD_1ABB) begin
         fails++;
         $display("FAIL wait_ack busy_cycles=%0d done@%0d rdata=%h exp 4 4 ccdd1abb",
                  t_busy, t_done_cyc, t_rdata);
      end
      ack_delay = 0;
   endtask

   task automatic test_timeout;
      ack_en = 1'b0;
      run_op(3'd2, 32'h102, 32'h0);
      tests_run++;
      if (t_done_cyc != 16 || t_bus !== 1'b1 || t_rdata !== 32'hCCDD_1ABB || t_busy != 16) begin
         fails++;
         $display("FAIL timeout done@%0d bus_err=%b rdata=%h busy=%0d exp 16 1 ccdd1abb 16",
                  t_done_cyc, t_bus, t_rdata, t_busy);
      end
      // ack arrives on the 15th REQ cycle, the same cycle the limit is hit
      ack_en = 1'b1; ack_delay = 14;
      run_op(3'd2, 32'h102, 32'h0);
      tests_run++;
      if (t_done_cyc != 16 || t_bus !== 1'b0 || t_rdata !== 32'hFFFF_CCDD) begin
         fails++;
         $display("FAIL ack_at_limit done@%0d bus_err=%b rdata=%h exp 16 0 ffffccdd",
                  t_done_cyc, t_bus, t_rdata);
      end
      ack_delay = 0;
   endtask

   task automatic test_start_while_busy;
      int          dc = -1;
      logic [31:0] rd = 32'h0;
      logic        ae = 1'b0;
      bit          addr_moved = 1'b0;
      ack_delay = 3;
      op = 3'd0; addr = 32'h103; start = 1'b1;
      for (int c = 1; c <= 40 && dc < 0; c++) begin
         @(negedge clk);
         // keep requesting a different (misaligned) op while the first is in flight
         if (c < 3) begin op = 3'd4; addr = 32'h102; start = 1'b1; end
         else start = 1'b0;
         #1;
         if (dm_req && dm_addr !== 10'h40) addr_moved = 1'b1;
         if (done) begin dc = c; rd = rdata; ae = align_err; end
      end
      start = 1'b0;
      @(negedge clk);
      #1;
      tests_run++;
      if (dc != 5 || rd !== 32'hFFFF_FFCC || ae !== 1'b0 || addr_moved) begin
         fails++;
         $display("FAIL start_while_busy done@%0d rdata=%h align=%b addr_moved=%b exp 5 ffffffcc 0 0",
                  dc, rd, ae, addr_moved);
      end
      tests_run++;
      if (busy !== 1'b0 || dm_req !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL idle_after_busy busy=%b req=%b done=%b exp 0 0 0", busy, dm_req, done);
      end
      @(negedge clk);
      ack_delay = 0;
   endtask

   task automatic test_ack_in_idle;
      ack_force = 1'b1;
      @(negedge clk);
      ack_force = 1'b0;
      #1;
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0 || rdata !== 32'hFFFF_FFCC) begin
         fails++;
         $display("FAIL ack_in_idle done=%b busy=%b rdata=%h exp 0 0 ffffffcc", done, busy, rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_op;
      ack_en = 1'b0;
      op = 3'd4; addr = 32'h100; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #1;
      tests_run++;
      if (dm_req !== 1'b1) begin
         fails++; $display("FAIL pre_reset_req dm_req=%b exp 1", dm_req);
      end
      reset = 1'b1;
      @(negedge clk);
      #1;
      tests_run++;
      if (dm_req !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0 || done !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_op req=%b busy=%b rdata=%h done=%b exp 0 0 00000000 0",
                  dm_req, busy, rdata, done);
      end
      reset = 1'b0; ack_en = 1'b1; ack_delay = 0;
      @(negedge clk);
      run_op(3'd4, 32'h100, 32'h0);
      tests_run++;
      if (t_done_cyc != 2 || t_rdata !== 32'hCCDD_1ABB || t_bus || t_align) begin
         fails++;
         $display("FAIL lw_after_reset done@%0d rdata=%h exp 2 ccdd1abb", t_done_cyc, t_rdata);
      end
   endtask

   initial begin
      test_reset();
      test_loads();
      test_stores();
      test_misaligned();
      test_wait_states();
      test_timeout();
      test_start_while_busy();
      test_ack_in_idle();
      test_reset_mid_op();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
